// File: rtl/traffic_light_fsm_if.sv
// rtl/traffic_light_fsm_if.sv - slow tick / pedestrian inputs and light outputs of the traffic light controller
// TLF_NIGHT_MODE_EN adds the night flash request.
interface traffic_light_fsm_if;
  logic       slow_clk;
  logic       ped_req;
`ifdef TLF_NIGHT_MODE_EN
  logic       night;
`endif
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk;
  logic [2:0] state_o;
  logic       tick_o;

  modport master (
`ifdef TLF_NIGHT_MODE_EN
    output night,
`endif
    output slow_clk, ped_req,
    input  main_lights, side_lights, walk, state_o, tick_o
  );

  modport slave (
`ifdef TLF_NIGHT_MODE_EN
    input  night,
`endif
    input  slow_clk, ped_req,
    output main_lights, side_lights, walk, state_o, tick_o
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - timed two-road traffic light with pedestrian request, stepped by slow_clk edges
// TLF_NIGHT_MODE_EN enables the night FLASH state and blink flop.
module traffic_light_fsm #(
  parameter int G_TIME = 8,
  parameter int MIN_G  = 3,
  parameter int S_TIME = 6,
  parameter int Y_TIME = 2,
  parameter int R_TIME = 1
) (
  input logic              in_clk,
  input logic              reset,
  traffic_light_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED1    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED2    = 3'd5
`ifdef TLF_NIGHT_MODE_EN
    , FLASH     = 3'd6
`endif
  } state_t;

  localparam logic [7:0] G_LAST   = 8'(G_TIME - 1);
  localparam logic [7:0] MIN_LAST = 8'(MIN_G - 1);
  localparam logic [7:0] S_LAST   = 8'(S_TIME - 1);
  localparam logic [7:0] Y_LAST   = 8'(Y_TIME - 1);
  localparam logic [7:0] R_LAST   = 8'(R_TIME - 1);

  state_t     state, state_nxt, go;
  logic [7:0] tcnt, tcnt_nxt;
  logic       slow_q, tick, ped_pending, ped_nxt, done, legal;
`ifdef TLF_NIGHT_MODE_EN
  logic       blink, blink_nxt;
`endif

  assign tick = bus.slow_clk & ~slow_q;

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      state       <= ALL_RED2;
      tcnt        <= '0;
      slow_q      <= 1'b0;
      ped_pending <= 1'b0;
`ifdef TLF_NIGHT_MODE_EN
      blink       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      slow_q      <= bus.slow_clk;
      ped_pending <= ped_nxt;
`ifdef TLF_NIGHT_MODE_EN
      blink       <= blink_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    go        = ALL_RED2;
    done      = 1'b0;
    legal     = 1'b1;
`ifdef TLF_NIGHT_MODE_EN
    blink_nxt = blink;
`endif
    case (state)
      MAIN_GREEN: begin
        // Pending request may cut green short once the minimum has elapsed.
        done = (tcnt == G_LAST) || (ped_pending && (tcnt >= MIN_LAST));
        go   = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin done = (tcnt == Y_LAST); go = ALL_RED1;    end
      ALL_RED1:    begin done = (tcnt == R_LAST); go = SIDE_GREEN;  end
      SIDE_GREEN:  begin done = (tcnt == S_LAST); go = SIDE_YELLOW; end
      SIDE_YELLOW: begin done = (tcnt == Y_LAST); go = ALL_RED2;    end
      ALL_RED2:    begin done = (tcnt == R_LAST); go = MAIN_GREEN;  end
`ifdef TLF_NIGHT_MODE_EN
      FLASH:       begin done = 1'b0;             go = FLASH;       end
`endif
      default:     legal = 1'b0;
    endcase

    if (!legal) begin
      state_nxt = ALL_RED2;
      tcnt_nxt  = '0;
    end else if (tick) begin
`ifdef TLF_NIGHT_MODE_EN
      if (bus.night) begin
        blink_nxt = (state == FLASH) ? ~blink : 1'b0;
        state_nxt = FLASH;
        tcnt_nxt  = '0;
      end else if (state == FLASH) begin
        state_nxt = ALL_RED2;
        tcnt_nxt  = '0;
      end else
`endif
      if (done) begin
        state_nxt = go;
        tcnt_nxt  = '0;
      end else begin
        tcnt_nxt  = tcnt + 8'd1;
      end
    end

    ped_nxt = bus.ped_req |
              (ped_pending & ~((state_nxt == SIDE_GREEN) && (state != SIDE_GREEN)));
  end

  always_comb begin
    bus.main_lights = 3'b100;
    bus.side_lights = 3'b100;
    bus.walk        = 1'b0;
    case (state)
      MAIN_GREEN:  bus.main_lights = 3'b001;
      MAIN_YELLOW: bus.main_lights = 3'b010;
      SIDE_GREEN:  begin bus.side_lights = 3'b001; bus.walk = 1'b1; end
      SIDE_YELLOW: bus.side_lights = 3'b010;
`ifdef TLF_NIGHT_MODE_EN
      FLASH: begin
        bus.main_lights = {1'b0, blink, 1'b0};
        bus.side_lights = {blink, 2'b00};
      end
`endif
      default: ;
    endcase
  end

  assign bus.state_o = state;
  assign bus.tick_o  = tick;

endmodule
